// File: rtl/mio_pkg.sv
// mio_pkg: register offsets, reset values and status bit positions for the MIO controller
package mio_pkg;
    localparam logic [15:0] KBSR_OFF = 16'd0;
    localparam logic [15:0] KBDR_OFF = 16'd2;
    localparam logic [15:0] DSR_OFF  = 16'd4;
    localparam logic [15:0] DDR_OFF  = 16'd6;
    localparam logic [15:0] MCR_RST  = 16'h8000;
    localparam int BIT_READY = 15;
    localparam int BIT_IE    = 14;
    localparam int BIT_OVF   = 13;
endpackage

// File: rtl/mio_sync_fifo.sv
// mio_sync_fifo: single-clock FIFO; a push while full is taken only if a pop frees the slot on the same edge
module mio_sync_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rp];
    // qualify requests against occupancy
    always_comb begin
        do_pop = pop & !empty;
        do_push = push & (!full | do_pop);
    end
    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mio_fifo_ctrl.sv
// mio_fifo_ctrl: LC-3 MIO controller with keyboard/display FIFOs; define MIO_INT_EN for interrupt support
module mio_fifo_ctrl
    import mio_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int KB_DEPTH = 4,
    parameter int DISP_DEPTH = 4,
    parameter logic [DATA_W-1:0] DEV_BASE = 16'hFE00,
    parameter logic [DATA_W-1:0] MCR_ADDR = 16'hFFFE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MIO_EN,
    input  logic              R_W,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] mio_out,
    output logic              R,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_d_out,
    input  logic              mem_r,
    input  logic [7:0]        kb_data,
    input  logic              kb_valid,
    output logic              kb_ready,
    output logic [7:0]        disp_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic              mcr_run,
    output logic              irq
);
    localparam int KCW = $clog2(KB_DEPTH) + 1;
    localparam int DCW = $clog2(DISP_DEPTH) + 1;
    logic [DATA_W-1:0] mcr, kbsr, dsr, dev_rdata;
    logic ie_kb, ie_disp, ovf;
    logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr, hit, commit, wr;
    logic kb_full, kb_empty, disp_full, disp_empty, kb_pop, disp_push, disp_pop;
    logic [KCW-1:0] kb_count;
    logic [DCW-1:0] disp_count;
    logic [7:0] kb_head;
    // address decode and access handshake; rst forces the handshake outputs idle
    always_comb begin
        sel_kbsr = a == DATA_W'(DEV_BASE + KBSR_OFF);
        sel_kbdr = a == DATA_W'(DEV_BASE + KBDR_OFF);
        sel_dsr = a == DATA_W'(DEV_BASE + DSR_OFF);
        sel_ddr = a == DATA_W'(DEV_BASE + DDR_OFF);
        sel_mcr = a == MCR_ADDR;
        hit = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr | sel_mcr;
        commit = !rst & MIO_EN & hit;
        wr = commit & R_W;
        kb_pop = commit & sel_kbdr & !R_W;
        disp_push = wr & sel_ddr;
        R = !rst & MIO_EN & (hit | mem_r);
        mem_en = !rst & MIO_EN & !hit;
        kb_ready = !rst & !kb_full;
        disp_valid = !rst & !disp_empty;
        disp_pop = disp_valid & disp_ready;
        mcr_run = rst | mcr[15];
    end
    // status register images and read mux
    always_comb begin
        kbsr = '0;
        kbsr[BIT_READY] = !kb_empty;
        kbsr[BIT_IE] = ie_kb;
        kbsr[KCW-1:0] = kb_count;
        dsr = '0;
        dsr[BIT_READY] = !disp_full;
        dsr[BIT_IE] = ie_disp;
        dsr[BIT_OVF] = ovf;
        dsr[DCW-1:0] = disp_count;
        dev_rdata = sel_kbsr ? kbsr :
                    sel_kbdr ? DATA_W'(kb_empty ? 8'h00 : kb_head) :
                    sel_dsr ? dsr :
                    sel_mcr ? mcr : '0;
        mio_out = !MIO_EN ? '0 : hit ? dev_rdata : mem_d_out;
    end
    // MCR and display overflow flag; a W1C clear wins since it cannot coincide with a DDR write
    always_ff @(posedge clk) begin
        if (rst) begin
            mcr <= DATA_W'(MCR_RST);
            ovf <= 1'b0;
        end else begin
            if (wr & sel_mcr) mcr <= d_in;
            if (wr & sel_dsr & d_in[BIT_OVF]) ovf <= 1'b0;
            else if (disp_push & disp_full & !disp_pop) ovf <= 1'b1;
        end
    end
`ifdef MIO_INT_EN
    // interrupt enable bits
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_kb <= 1'b0;
            ie_disp <= 1'b0;
        end else begin
            if (wr & sel_kbsr) ie_kb <= d_in[BIT_IE];
            if (wr & sel_dsr) ie_disp <= d_in[BIT_IE];
        end
    end
    assign irq = !rst & ((!kb_empty & ie_kb) | (!disp_full & ie_disp));
`else
    assign ie_kb = 1'b0;
    assign ie_disp = 1'b0;
    assign irq = 1'b0;
`endif
    mio_sync_fifo #(.W(8), .DEPTH(KB_DEPTH)) u_kb (
        .clk(clk), .rst(rst), .push(kb_valid & kb_ready), .pop(kb_pop), .din(kb_data),
        .dout(kb_head), .full(kb_full), .empty(kb_empty), .count(kb_count)
    );
    mio_sync_fifo #(.W(8), .DEPTH(DISP_DEPTH)) u_disp (
        .clk(clk), .rst(rst), .push(disp_push), .pop(disp_pop), .din(d_in[7:0]),
        .dout(disp_data), .full(disp_full), .empty(disp_empty), .count(disp_count)
    );
endmodule

// File: tb/tb_mio_fifo_ctrl.sv
// tb_mio_fifo_ctrl: queue-based reference model with a read-data scoreboard and per-cycle output monitor
module tb_mio_fifo_ctrl;
    localparam int KD = 4;
    localparam int DD = 4;
    localparam logic [15:0] BASE = 16'hFE00;
    localparam logic [15:0] MCRA = 16'hFFFE;
    logic clk = 0, rst, MIO_EN, R_W, R, mem_en, mem_r, kb_valid, kb_ready, disp_valid, disp_ready, mcr_run, irq;
    logic [15:0] a, d_in, mio_out, mem_d_out;
    logic [7:0] kb_data, disp_data;
    logic [7:0] kbq[$], dq[$];
    logic [15:0] exp_rd[$];
    logic m_ovf = 0, m_iek = 0, m_ied = 0;
    logic [15:0] m_mcr = 16'h8000;
    logic [15:0] devs [5] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE};
    bit bg = 0;
    int total = 0, bad = 0;

    mio_fifo_ctrl dut (
        .clk(clk), .rst(rst), .MIO_EN(MIO_EN), .R_W(R_W), .a(a), .d_in(d_in), .mio_out(mio_out),
        .R(R), .mem_en(mem_en), .mem_d_out(mem_d_out), .mem_r(mem_r), .kb_data(kb_data),
        .kb_valid(kb_valid), .kb_ready(kb_ready), .disp_data(disp_data), .disp_valid(disp_valid),
        .disp_ready(disp_ready), .mcr_run(mcr_run), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic bit is_dev(input logic [15:0] x);
        return x == BASE || x == BASE + 2 || x == BASE + 4 || x == BASE + 6 || x == MCRA;
    endfunction

    function automatic logic [15:0] model_rd(input logic [15:0] x);
        if (x == BASE) return {kbq.size() != 0, m_iek, 14'(kbq.size())};
        if (x == BASE + 2) return kbq.size() != 0 ? {8'h00, kbq[0]} : 16'h0000;
        if (x == BASE + 4) return {dq.size() < DD, m_ied, m_ovf, 13'(dq.size())};
        if (x == MCRA) return m_mcr;
        return 16'h0000;
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    // reference model: device state as byte queues, updated on each rising edge
    always @(posedge clk) begin : mdl
        bit cm, kpop, kpush, dpop;
        if (rst) begin
            kbq.delete();
            dq.delete();
            m_ovf = 0;
            m_iek = 0;
            m_ied = 0;
            m_mcr = 16'h8000;
        end else begin
            cm = MIO_EN && is_dev(a);
            kpop = cm && !R_W && a == BASE + 2 && kbq.size() > 0;
            kpush = kb_valid && kbq.size() < KD;
            dpop = disp_ready && dq.size() > 0;
            if (kpop) void'(kbq.pop_front());
            if (kpush) kbq.push_back(kb_data);
            if (dpop) void'(dq.pop_front());
            if (cm && R_W) begin
                if (a == BASE + 6) begin
                    if (dq.size() < DD) dq.push_back(d_in[7:0]);
                    else m_ovf = 1;
                end
                if (a == BASE + 4 && d_in[13]) m_ovf = 0;
`ifdef MIO_INT_EN
                if (a == BASE) m_iek = d_in[14];
                if (a == BASE + 4) m_ied = d_in[14];
`endif
                if (a == MCRA) m_mcr = d_in;
            end
        end
    end

    // monitor: outputs against the model, read data against the scoreboard
    always @(negedge clk) begin : mon
        bit h;
        h = is_dev(a);
        check("R", R, !rst && MIO_EN && (h || mem_r));
        check("mem_en", mem_en, !rst && MIO_EN && !h);
        check("kb_ready", kb_ready, !rst && kbq.size() < KD);
        check("disp_valid", disp_valid, !rst && dq.size() > 0);
        if (!rst && dq.size() > 0) check("disp_data", disp_data, dq[0]);
        check("mcr_run", mcr_run, rst || m_mcr[15]);
`ifdef MIO_INT_EN
        check("irq", irq, !rst && ((kbq.size() > 0 && m_iek) || (dq.size() < DD && m_ied)));
`else
        check("irq", irq, 0);
`endif
        if (!MIO_EN) check("mio_idle", mio_out, 16'h0000);
        else if (R && !R_W) begin
            if (exp_rd.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected got=%h t=%0t", mio_out, $time);
            end else check("rd_data", mio_out, exp_rd.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bg) begin
            kb_valid = 1'($urandom_range(0, 1));
            kb_data = 8'($urandom);
            disp_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic dev_acc(input bit rw, input logic [15:0] addr, input logic [15:0] data,
                           input bit chk = 0, input logic [15:0] want = 0);
        MIO_EN = 1;
        R_W = rw;
        a = addr;
        d_in = data;
        if (!rw) exp_rd.push_back(model_rd(addr));
        @(negedge clk);
        if (chk) check("plan_rd", mio_out, want);
        cyc();
        MIO_EN = 0;
    endtask

    task automatic mem_acc(input bit rw, input logic [15:0] addr, input int waits, input bit chk = 0);
        MIO_EN = 1;
        R_W = rw;
        a = addr;
        d_in = 16'($urandom);
        mem_r = 0;
        for (int i = 0; i < waits; i++) begin
            mem_d_out = 16'($urandom);
            @(negedge clk);
            if (chk) check("mem_wait_R", R, 0);
            cyc();
        end
        mem_r = 1;
        mem_d_out = 16'($urandom);
        if (!rw) exp_rd.push_back(mem_d_out);
        cyc();
        mem_r = 0;
        MIO_EN = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] x;
        rst = 1; MIO_EN = 0; R_W = 0; a = 0; d_in = 0; mem_d_out = 0; mem_r = 0;
        kb_data = 0; kb_valid = 0; disp_ready = 0;
        repeat (2) cyc();
        rst = 0;
        dev_acc(0, BASE, 0, 1, 16'h0000);
        dev_acc(0, BASE + 4, 0, 1, 16'h8000);
        dev_acc(0, MCRA, 0, 1, 16'h8000);
        kb_valid = 1; kb_data = 8'h41; cyc();
        kb_data = 8'h42; cyc();
        kb_valid = 0;
        dev_acc(0, BASE, 0, 1, 16'h8002);
        dev_acc(0, BASE + 2, 0, 1, 16'h0041);
        dev_acc(0, BASE + 2, 0, 1, 16'h0042);
        dev_acc(0, BASE + 2, 0, 1, 16'h0000);
        dev_acc(0, BASE, 0, 1, 16'h0000);
        disp_ready = 0;
        for (int i = 0; i < 5; i++) dev_acc(1, BASE + 6, 16'h0010 + 16'(i));
        dev_acc(0, BASE + 4, 0, 1, 16'h2004);
        dev_acc(1, BASE + 4, 16'h2000);
        dev_acc(0, BASE + 4, 0, 1, 16'h0004);
        disp_ready = 1;
        repeat (6) cyc();
        disp_ready = 0;
        dev_acc(0, BASE + 4, 0, 1, 16'h8000);
        mem_acc(0, 16'h3000, 3, 1);
        dev_acc(1, MCRA, 16'h0000);
        @(negedge clk);
        check("mcr_run_cleared", mcr_run, 0);
        cyc();
        MIO_EN = 1; R_W = 0; a = 16'h3000; mem_r = 0;
        cyc();
        rst = 1;
        @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_R", R, 0);
        cyc();
        rst = 0;
        MIO_EN = 0;
        dev_acc(0, MCRA, 0, 1, 16'h8000);
`ifdef MIO_INT_EN
        dev_acc(1, BASE, 16'h4000);
        kb_valid = 1; kb_data = 8'h5A; cyc();
        kb_valid = 0;
        @(negedge clk);
        check("irq_set", irq, 1);
        cyc();
        dev_acc(0, BASE + 2, 0, 1, 16'h005A);
        @(negedge clk);
        check("irq_clr", irq, 0);
        cyc();
`endif
        bg = 1;
        repeat (400) begin
            case ($urandom_range(0, 4))
                0: dev_acc(0, devs[$urandom_range(0, 4)], 0);
                1: dev_acc(1, devs[$urandom_range(0, 4)], 16'($urandom));
                2: begin
                    do x = 16'($urandom); while (is_dev(x));
                    mem_acc(1'($urandom_range(0, 1)), x, $urandom_range(0, 3));
                end
                3: dev_acc(1, BASE + 6, 16'($urandom));
                default: cyc();
            endcase
        end
        bg = 0;
        kb_valid = 0;
        MIO_EN = 0;
        repeat (3) cyc();
        check("scoreboard_left", 16'(exp_rd.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mio_fifo_ctrl.md
Name: mio_fifo_ctrl

Overview:
Second-generation LC-3 memory-mapped I/O controller between the datapath's MIO access and external memory.
- Decodes the keyboard, display and MCR device registers and forwards every other address to memory.
- Adds parametrised receive/transmit FIFOs, occupancy reporting, overflow detection and a memory wait-state handshake passed through to the datapath.

Parameters:
DATA_W, 16, address and data width
KB_DEPTH, 4, keyboard FIFO entries (power of two, >=2)
DISP_DEPTH, 4, display FIFO entries (power of two, >=2)
DEV_BASE, 16'hFE00, address of KBSR; KBDR=+2, DSR=+4, DDR=+6
MCR_ADDR, 16'hFFFE, machine control register address

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
MIO_EN  in  1  access request, held until R=1
R_W  in  1  1=write, 0=read
a  in  DATA_W  access address
d_in  in  DATA_W  write data
mio_out  out  DATA_W  read data
R  out  1  access complete
mem_en  out  1  memory enable
mem_d_out  in  DATA_W  memory read data
mem_r  in  1  memory ready
kb_data  in  8  keyboard character
kb_valid  in  1  keyboard offers character
kb_ready  out  1  controller accepts character
disp_data  out  8  display character
disp_valid  out  1  character available
disp_ready  in  1  display consumes character
mcr_run  out  1  MCR[15], clock-run
irq  out  1  interrupt request (see Optional Feature)

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high.
- Reset state: both FIFOs empty, overflow=0, IE bits=0, MCR=16'h8000.
- While rst=1 the following are forced: R=0, mem_en=0, kb_ready=0, disp_valid=0, irq=0, mcr_run=1.
- Decode: device hit = a matches one of the five device addresses. Any other address is a memory access.
- Device access:
  - R=MIO_EN, combinationally.
  - Read data is combinational on mio_out.
  - Side effects commit on the rising edge where MIO_EN&R=1.
- Memory access:
  - mem_en=MIO_EN&!hit; R=mem_r; mio_out=mem_d_out.
  - Any number of wait states is allowed.
  - Reset mid-access drops mem_en and abandons the access.
- When MIO_EN=0: mio_out=0, R=0.
- KBSR read value: {!kb_empty, IE_kb, count zero-extended to 14 bits}.
  - Writes change bit14 only.
- KBDR read value: {8'h00, FIFO head}, popping the head at the commit edge.
  - Read when empty returns 16'h0000 and pops nothing.
  - KBDR writes are ignored.
- Keyboard FIFO push:
  - kb_ready=!kb_full; push on kb_valid&kb_ready.
  - Simultaneous push and pop: both occur, count unchanged.
  - When full, kb_ready is low, so a pop frees the slot for the next cycle.
- DSR read value: {!disp_full, IE_disp, ovf, count zero-extended to 13 bits}.
  - Bit14 is writable.
  - Writing bit13=1 clears ovf (W1C).
- DDR write: pushes d_in[7:0] at the commit edge.
  - If the FIFO is full, the data is dropped and ovf is set.
  - A pop on the same edge frees a slot, so the push is accepted with no overflow.
  - DDR read returns 16'h0000.
- Display FIFO output:
  - disp_valid=!disp_empty; disp_data=head.
  - Pop on disp_valid&disp_ready.
- MCR: full 16-bit read/write; mcr_run=MCR[15].
- Counts saturate at depth; FIFO pointers wrap modulo depth.

Optional Feature:
MIO_INT_EN:
- When defined: irq=(!kb_empty&IE_kb)|(!disp_full&IE_disp), combinational.
- When undefined:
  - irq tied 0.
  - Bit14 of KBSR/DSR reads 0 and writes are ignored.

Decomposition:
- Package mio_pkg holds:
  - register offset constants (KBSR 0, KBDR 2, DSR 4, DDR 6);
  - MCR reset value 16'h8000;
  - status bit indices (READY 15, IE 14, OVF 13).
- One natural sub-module, mio_sync_fifo: parametrised width/depth synchronous FIFO with full, empty and count outputs.
  - Instantiated twice: keyboard 8-bit, display 8-bit.

Test Plan:
- Reset, then read KBSR, DSR, MCR -> 16'h0000, 16'h8000, 16'h8000; mcr_run=1; kb_ready=1.
- Push 'A'(8'h41) and 'B'(8'h42) via kb_valid; read KBSR -> 16'h8002; read KBDR twice -> 16'h0041, 16'h0042; third read -> 16'h0000; KBSR -> 16'h0000.
- Hold disp_ready=0 and write DDR five times (DISP_DEPTH=4) -> DSR=16'h2004. Then write DSR with 16'h2000 -> ovf cleared. Then drain with disp_ready=1 -> bytes appear in write order.
- Memory read at 16'h3000 with mem_r low for 3 cycles -> R low for 3 cycles; mio_out=mem_d_out when R rises; mem_en=0 for device addresses.
- Write MCR 16'h0000 -> mcr_run=0 next cycle. Assert rst mid memory access -> mem_en=0 and R=0 the next cycle, MCR=16'h8000.
- With MIO_INT_EN: set KBSR=16'h4000, then push a key -> irq=1; read KBDR -> irq=0.
